// File: rtl/ct_ifu_precode_refill_ctrl_pkg.sv
// Shared IFU refill definitions.
// Holds the line geometry and the refill FSM state encoding.
// The precode unit and the refill controller both import this package.
package ct_ifu_precode_refill_ctrl_pkg;

  localparam int BEAT_NUM  = 4;
  localparam int BEAT_W    = 128;
  localparam int PRECODE_W = 32;
  localparam int HW_NUM    = BEAT_W / 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } refill_state_e;

endpackage

// File: rtl/ct_ifu_precode.sv
// Combinational precode of one 128-bit refill beat.
// Ports:
//   inst_data : beat payload. Halfword h1 is at [127:112] and h8 is at [15:0].
//   precode   : one nibble {ab_br, br, bry1, bry0} per halfword, stored in the
//               same position order as the halfwords (h1 nibble at [31:28]).
// bry1 marks boundaries assuming h1 starts an instruction.
// bry0 marks boundaries assuming h1 is the tail of an instruction from the
// previous beat, so the walk restarts at h2. The h1 slot is still flagged
// in this view, so a consumer can use either view without masking h1.
module ct_ifu_precode
  import ct_ifu_precode_refill_ctrl_pkg::*;
(
  input  logic [BEAT_W-1:0]    inst_data,
  output logic [PRECODE_W-1:0] precode
);

  logic [15:0] hw;
  logic        is32;
  logic        ab_br;
  logic        br;
  logic        start1;
  logic        start0;

  always_comb begin
    precode = '0;
    hw      = '0;
    is32    = 1'b0;
    ab_br   = 1'b0;
    br      = 1'b0;
    start1  = 1'b1;
    start0  = 1'b0;
    for (int i = HW_NUM - 1; i >= 0; i--) begin
      hw   = inst_data[16*i +: 16];
      is32 = (hw[1:0] == 2'b11);
      if (is32) begin
        // jal is the unconditional direct jump; beq-class is conditional.
        ab_br = (hw[6:0] == 7'b1101111);
        br    = ab_br || (hw[6:0] == 7'b1100011);
      end else begin
        // c.j is the unconditional direct jump; c.beqz/c.bnez are conditional.
        ab_br = (hw[1:0] == 2'b01) && (hw[15:13] == 3'b101);
        br    = ab_br || ((hw[1:0] == 2'b01) && (hw[15:14] == 2'b11));
      end
      precode[4*i +: 4] = {ab_br, br, start1, (i == HW_NUM - 1) ? 1'b1 : start0};
      start1 = !(start1 && is32);
      start0 = !(start0 && is32);
    end
  end

endmodule

// File: rtl/ct_ifu_precode_refill_ctrl.sv
// Instruction-cache line refill controller with inline precode.
// It collects four 128-bit beats and precodes each beat as it is accepted.
// It also tracks whether h1 of each beat starts an instruction.
// When the line is complete it presents the line to the icache as a single write.
//
// Ports:
//   forever_cpuclk, cpurst_b            : clock, async active-low reset
//   ifu_refill_start                    : begin a refill (IDLE only)
//   refill_data_vld/rdy, refill_data    : beat handshake and payload
//   pcgen_flush                         : abort the refill in flight
//   icache_wr_vld/rdy                   : line write handshake
//   icache_wr_data/precode/h1_start     : assembled line, per-beat slots
//   refill_done                         : pulse the cycle after the write handshake
//   ctrl_busy                           : controller not idle
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for ifu_refill_start
// ST_FILL  | accepting beats 0..3 into the line buffers
// ST_WRITE | line complete, icache_wr_vld held until handshake
module ct_ifu_precode_refill_ctrl
  import ct_ifu_precode_refill_ctrl_pkg::*;
(
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  input  logic                          ifu_refill_start,
  input  logic                          refill_data_vld,
  input  logic [BEAT_W-1:0]             refill_data,
  output logic                          refill_data_rdy,
  input  logic                          pcgen_flush,
  output logic                          icache_wr_vld,
  input  logic                          icache_wr_rdy,
  output logic [BEAT_NUM*BEAT_W-1:0]    icache_wr_data,
  output logic [BEAT_NUM*PRECODE_W-1:0] icache_wr_precode,
  output logic [BEAT_NUM-1:0]           icache_wr_h1_start,
  output logic                          refill_done,
  output logic                          ctrl_busy
);

  refill_state_e state, state_nxt;

  logic [1:0]                            beat_cnt;
  logic                                  h1_start;
  logic                                  h1_start_nxt;
  logic                                  sel_h8_bry;
  logic                                  beat_acc;
  logic                                  fill_go;
  logic [PRECODE_W-1:0]                  beat_precode;
  logic [BEAT_NUM-1:0][BEAT_W-1:0]       data_buf;
  logic [BEAT_NUM-1:0][PRECODE_W-1:0]    pc_buf;
  logic [BEAT_NUM-1:0]                   h1_buf;

  ct_ifu_precode u_precode (
    .inst_data (refill_data),
    .precode   (beat_precode)
  );

  // The carry into the next beat depends on h8 only if h8 is a boundary
  // under the view that matches this beat's h1 status.
  assign sel_h8_bry   = h1_start ? beat_precode[1] : beat_precode[0];
  assign h1_start_nxt = !(sel_h8_bry && (refill_data[1:0] == 2'b11));

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    refill_data_rdy = 1'b0;
    icache_wr_vld   = 1'b0;
    ctrl_busy       = 1'b1;
    beat_acc        = 1'b0;
    fill_go         = 1'b0;
    case (state)
      ST_IDLE: begin
        ctrl_busy = 1'b0;
        if (ifu_refill_start && !pcgen_flush) begin
          fill_go   = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        refill_data_rdy = !pcgen_flush;
        beat_acc        = refill_data_vld && !pcgen_flush;
        if (pcgen_flush)                       state_nxt = ST_IDLE;
        else if (beat_acc && beat_cnt == 2'd3) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        icache_wr_vld = 1'b1;
        // A flush in the handshake cycle still lets the write complete.
        if (icache_wr_rdy || pcgen_flush) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      beat_cnt    <= 2'd0;
      h1_start    <= 1'b1;
      data_buf    <= '0;
      pc_buf      <= '0;
      h1_buf      <= '0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= (state == ST_WRITE) && icache_wr_rdy;
      if (fill_go) begin
        beat_cnt <= 2'd0;
        h1_start <= 1'b1;
      end else if (beat_acc) begin
        data_buf[beat_cnt] <= refill_data;
        pc_buf[beat_cnt]   <= beat_precode;
        h1_buf[beat_cnt]   <= h1_start;
        beat_cnt           <= beat_cnt + 2'd1;
        h1_start           <= h1_start_nxt;
      end
    end
  end

  assign icache_wr_data     = data_buf;
  assign icache_wr_precode  = pc_buf;
  assign icache_wr_h1_start = h1_buf;

endmodule

// File: tb/tb_ct_ifu_precode_refill_ctrl.sv
module tb_ct_ifu_precode_refill_ctrl;

  logic         forever_cpuclk;
  logic         cpurst_b;
  logic         ifu_refill_start;
  logic         refill_data_vld;
  logic [127:0] refill_data;
  logic         refill_data_rdy;
  logic         pcgen_flush;
  logic         icache_wr_vld;
  logic         icache_wr_rdy;
  logic [511:0] icache_wr_data;
  logic [127:0] icache_wr_precode;
  logic [3:0]   icache_wr_h1_start;
  logic         refill_done;
  logic         ctrl_busy;

  ct_ifu_precode_refill_ctrl dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst_b           (cpurst_b),
    .ifu_refill_start   (ifu_refill_start),
    .refill_data_vld    (refill_data_vld),
    .refill_data        (refill_data),
    .refill_data_rdy    (refill_data_rdy),
    .pcgen_flush        (pcgen_flush),
    .icache_wr_vld      (icache_wr_vld),
    .icache_wr_rdy      (icache_wr_rdy),
    .icache_wr_data     (icache_wr_data),
    .icache_wr_precode  (icache_wr_precode),
    .icache_wr_h1_start (icache_wr_h1_start),
    .refill_done        (refill_done),
    .ctrl_busy          (ctrl_busy)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    string        tag;
    logic [511:0] line;
    logic [3:0]   h1s;
    logic [127:0] pc;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_refill_start = 1'b0;
    refill_data_vld  = 1'b0;
    refill_data      = '0;
    pcgen_flush      = 1'b0;
    icache_wr_rdy    = 1'b0;
  endtask

  // Reference model: instruction-stream walk over halfwords.
  function automatic logic [1:0] kind(input logic [15:0] hw);
    logic [1:0] k;
    k = 2'b00;
    if (hw[1:0] == 2'b11) begin
      if (hw[6:0] == 7'h6F)      k = 2'b11;
      else if (hw[6:0] == 7'h63) k = 2'b01;
    end else if (hw[1:0] == 2'b01) begin
      if (hw[15:13] == 3'b101)     k = 2'b11;
      else if (hw[15:14] == 2'b11) k = 2'b01;
    end
    return k;
  endfunction

  // bit j = halfword h(j+1) begins an instruction, given h1's status
  function automatic logic [7:0] starts(input logic [127:0] beat, input logic first);
    logic [7:0]  s;
    logic        cur;
    logic [15:0] hw;
    s   = '0;
    cur = first;
    for (int j = 0; j < 8; j++) begin
      hw   = beat[16*(7-j) +: 16];
      s[j] = cur;
      cur  = !(cur && hw[1:0] == 2'b11);
    end
    return s;
  endfunction

  function automatic logic [127:0] exp_precode(input logic [511:0] line);
    logic [127:0] pc;
    logic [127:0] beat;
    logic [7:0]   s1, s0;
    logic [15:0]  hw;
    pc = '0;
    for (int b = 0; b < 4; b++) begin
      beat  = line[128*b +: 128];
      s1    = starts(beat, 1'b1);
      s0    = starts(beat, 1'b0);
      s0[0] = 1'b1;
      for (int j = 0; j < 8; j++) begin
        hw = beat[16*(7-j) +: 16];
        pc[32*b + 4*(7-j) +: 4] = {kind(hw), s1[j], s0[j]};
      end
    end
    return pc;
  endfunction

  function automatic logic [3:0] exp_h1s(input logic [511:0] line);
    logic [3:0]   h;
    logic         cur;
    logic [127:0] beat;
    logic [7:0]   s;
    h   = '0;
    cur = 1'b1;
    for (int b = 0; b < 4; b++) begin
      h[b] = cur;
      beat = line[128*b +: 128];
      s    = starts(beat, cur);
      cur  = !(s[7] && beat[1:0] == 2'b11);
    end
    return h;
  endfunction

  task automatic feed(input logic [511:0] line, input int n);
    for (int b = 0; b < n; b++) begin
      refill_data_vld = 1'b1;
      refill_data     = line[128*b +: 128];
      tick();
    end
    refill_data_vld = 1'b0;
    refill_data     = '0;
  endtask

  task automatic run_line(input string tag, input logic [511:0] line,
                          input logic [3:0] eh, input logic [127:0] ep);
    ifu_refill_start = 1'b1;
    settle();
    chk({tag, "_idle_rdy"}, refill_data_rdy, 1'b0);
    tick();
    ifu_refill_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      refill_data_vld = 1'b1;
      refill_data     = line[128*b +: 128];
      settle();
      chk({tag, "_rdy"}, refill_data_rdy, 1'b1);
      chk({tag, "_vld_early"}, icache_wr_vld, 1'b0);
      chk({tag, "_busy_fill"}, ctrl_busy, 1'b1);
      tick();
    end
    refill_data_vld = 1'b0;
    settle();
    chk({tag, "_wr_vld"}, icache_wr_vld, 1'b1);
    chk({tag, "_wr_data"}, icache_wr_data, line);
    chk({tag, "_precode"}, icache_wr_precode, ep);
    chk({tag, "_h1s"}, icache_wr_h1_start, eh);
    chk({tag, "_done_early"}, refill_done, 1'b0);
    icache_wr_rdy = 1'b1;
    tick();
    icache_wr_rdy = 1'b0;
    settle();
    chk({tag, "_done"}, refill_done, 1'b1);
    chk({tag, "_vld_off"}, icache_wr_vld, 1'b0);
    chk({tag, "_busy_off"}, ctrl_busy, 1'b0);
    tick();
    settle();
    chk({tag, "_done_pulse"}, refill_done, 1'b0);
  endtask

  logic [511:0] all1;
  logic [511:0] tmp;
  logic         m_busy, m_writing, m_done, nd;
  int           m_beats;
  logic [511:0] m_line;

  initial begin
    idle_inputs();
    cpurst_b = 1'b0;

    all1 = {32{16'h0001}};
    vecs[0].tag = "allnop"; vecs[0].line = all1;
    vecs[0].h1s = 4'b1111;  vecs[0].pc = {4{32'h3333_3333}};

    tmp = all1; tmp[15:0] = 16'h0013;
    vecs[1].tag = "cross32"; vecs[1].line = tmp;
    vecs[1].h1s = 4'b1101;   vecs[1].pc = {4{32'h3333_3333}};

    tmp = all1; tmp[383:368] = 16'h006F;
    vecs[2].tag = "jal_b2"; vecs[2].line = tmp;
    vecs[2].h1s = 4'b1111;  vecs[2].pc = {32'h3333_3333, 32'hF133_3333, 32'h3333_3333, 32'h3333_3333};

    tmp = all1; tmp[15:0] = 16'h0063; tmp[511:496] = 16'hA001; tmp[495:480] = 16'hC001;
    vecs[3].tag = "branches"; vecs[3].line = tmp;
    vecs[3].h1s = 4'b1101;    vecs[3].pc = {32'hF733_3333, 32'h3333_3333, 32'h3333_3333, 32'h3333_3337};

    tmp = all1; tmp[15:0] = 16'h0013; tmp[255:128] = {8{16'h0013}};
    vecs[4].tag = "tailview"; vecs[4].line = tmp;
    vecs[4].h1s = 4'b1001;    vecs[4].pc = {32'h3333_3333, 32'h3333_3333, 32'h3121_2121, 32'h3333_3333};

    #12;
    chk("rst_busy", ctrl_busy, 1'b0);
    chk("rst_wr_vld", icache_wr_vld, 1'b0);
    chk("rst_done", refill_done, 1'b0);
    chk("rst_rdy", refill_data_rdy, 1'b0);
    chk("rst_data", icache_wr_data, '0);
    chk("rst_precode", icache_wr_precode, '0);
    chk("rst_h1s", icache_wr_h1_start, 4'b0000);
    cpurst_b = 1'b1;
    tick();

    for (int i = 0; i < 5; i++)
      run_line(vecs[i].tag, vecs[i].line, vecs[i].h1s, vecs[i].pc);

    // flush after two beats, then a clean refill
    ifu_refill_start = 1'b1; tick(); ifu_refill_start = 1'b0;
    feed(vecs[1].line, 2);
    pcgen_flush = 1'b1; refill_data_vld = 1'b1;
    settle();
    chk("flush_rdy", refill_data_rdy, 1'b0);
    tick();
    pcgen_flush = 1'b0; refill_data_vld = 1'b0;
    settle();
    chk("flush_busy", ctrl_busy, 1'b0);
    chk("flush_vld", icache_wr_vld, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      chk("flush_no_vld", icache_wr_vld, 1'b0);
      chk("flush_no_done", refill_done, 1'b0);
    end
    run_line("after_flush", vecs[0].line, vecs[0].h1s, vecs[0].pc);

    // write back-pressure, start ignored in WRITE and in handshake cycle
    ifu_refill_start = 1'b1; tick(); ifu_refill_start = 1'b0;
    feed(vecs[2].line, 4);
    for (int c = 0; c < 5; c++) begin
      ifu_refill_start = 1'b1;
      settle();
      chk("bp_vld", icache_wr_vld, 1'b1);
      chk("bp_data", icache_wr_data, vecs[2].line);
      chk("bp_precode", icache_wr_precode, vecs[2].pc);
      chk("bp_h1s", icache_wr_h1_start, vecs[2].h1s);
      chk("bp_done", refill_done, 1'b0);
      tick();
    end
    icache_wr_rdy = 1'b1;
    settle();
    chk("bp_vld_hs", icache_wr_vld, 1'b1);
    tick();
    icache_wr_rdy = 1'b0; ifu_refill_start = 1'b0;
    settle();
    chk("bp_done_pulse", refill_done, 1'b1);
    chk("bp_start_ignored", ctrl_busy, 1'b0);
    tick(); settle();
    chk("bp_done_one", refill_done, 1'b0);
    chk("bp_still_idle", ctrl_busy, 1'b0);

    // flush coinciding with the 4th beat
    ifu_refill_start = 1'b1; tick(); ifu_refill_start = 1'b0;
    feed(vecs[0].line, 3);
    refill_data_vld = 1'b1; refill_data = vecs[0].line[511:384]; pcgen_flush = 1'b1;
    settle();
    chk("f4_rdy", refill_data_rdy, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("f4_busy", ctrl_busy, 1'b0);
    chk("f4_vld", icache_wr_vld, 1'b0);
    tick(); settle();
    chk("f4_no_done", refill_done, 1'b0);

    // flush coinciding with the write handshake
    ifu_refill_start = 1'b1; tick(); ifu_refill_start = 1'b0;
    feed(vecs[3].line, 4);
    icache_wr_rdy = 1'b1; pcgen_flush = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("fhs_done", refill_done, 1'b1);
    chk("fhs_busy", ctrl_busy, 1'b0);

    // flush with start in IDLE
    ifu_refill_start = 1'b1; pcgen_flush = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("fidle_busy", ctrl_busy, 1'b0);
    chk("fidle_rdy", refill_data_rdy, 1'b0);

    // reset mid-refill
    ifu_refill_start = 1'b1; tick(); ifu_refill_start = 1'b0;
    feed(vecs[4].line, 2);
    cpurst_b = 1'b0;
    #2;
    chk("mrst_busy", ctrl_busy, 1'b0);
    chk("mrst_vld", icache_wr_vld, 1'b0);
    chk("mrst_data", icache_wr_data, '0);
    chk("mrst_h1s", icache_wr_h1_start, 4'b0000);
    #2;
    cpurst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      chk("mrst_no_vld", icache_wr_vld, 1'b0);
      chk("mrst_no_done", refill_done, 1'b0);
    end

    // randomized traffic against the stream model
    m_busy = 1'b0; m_writing = 1'b0; m_done = 1'b0; m_beats = 0; m_line = '0;
    for (int c = 0; c < 3000; c++) begin
      ifu_refill_start = ($urandom_range(0, 3) == 0);
      refill_data_vld  = ($urandom_range(0, 9) < 7);
      refill_data      = {$urandom, $urandom, $urandom, $urandom};
      pcgen_flush      = ($urandom_range(0, 39) == 0);
      icache_wr_rdy    = ($urandom_range(0, 1) == 1);
      settle();
      chk("rnd_rdy", refill_data_rdy, m_busy && !m_writing && !pcgen_flush);
      chk("rnd_vld", icache_wr_vld, m_writing);
      chk("rnd_busy", ctrl_busy, m_busy);
      chk("rnd_done", refill_done, m_done);
      if (m_writing) begin
        chk("rnd_data", icache_wr_data, m_line);
        chk("rnd_precode", icache_wr_precode, exp_precode(m_line));
        chk("rnd_h1s", icache_wr_h1_start, exp_h1s(m_line));
      end
      nd = m_writing && icache_wr_rdy;
      if (!m_busy) begin
        if (ifu_refill_start && !pcgen_flush) begin
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end else if (!m_writing) begin
        if (pcgen_flush) m_busy = 1'b0;
        else if (refill_data_vld) begin
          m_line[128*m_beats +: 128] = refill_data;
          m_beats++;
          if (m_beats == 4) m_writing = 1'b1;
        end
      end else if (icache_wr_rdy || pcgen_flush) begin
        m_busy    = 1'b0;
        m_writing = 1'b0;
      end
      m_done = nd;
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
